// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the 7-to-1 bit-select mux stage.
// Captures a 7-bit word and a length on Start, then steps the mux select
// from 0 to length-1. Each select value is held for TICKS clock cycles, so
// the mux output presents the word serially, LSB first.
module mux_scan_sequencer #(
    parameter int TICKS = 25000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [6:0] DataIn,
    input  logic [2:0] Length,
    output logic [6:0] MuxIn,
    output logic [2:0] MuxSelect,
    output logic       Busy,
    output logic       BitStrobe,
    output logic       Done
);

    localparam int CW = $clog2(TICKS) + 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICKS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [2:0]    len_reg;
    logic [2:0]    len_next;
    logic [6:0]    mux_in_next;
    logic [2:0]    select_next;
    logic          busy_next;
    logic          strobe_next;
    logic          done_next;

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            len_reg   <= '0;
            MuxIn     <= '0;
            MuxSelect <= '0;
            Busy      <= 1'b0;
            BitStrobe <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            len_reg   <= len_next;
            MuxIn     <= mux_in_next;
            MuxSelect <= select_next;
            Busy      <= busy_next;
            BitStrobe <= strobe_next;
            Done      <= done_next;
        end
    end

    // Next-state logic: accept a scan in IDLE, advance the select in RUN
    always_comb begin
        state_next  = state;
        count_next  = count;
        len_next    = len_reg;
        mux_in_next = MuxIn;
        select_next = MuxSelect;
        busy_next   = Busy;
        strobe_next = 1'b0;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (Start) begin
                    mux_in_next = DataIn;
                    len_next    = (Length == 3'd0) ? 3'd7 : Length;
                    select_next = 3'd0;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    strobe_next = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (count == TICK_MAX) begin
                    count_next = '0;
                    if (MuxSelect == len_reg - 3'd1) begin
                        select_next = 3'd0;
                        mux_in_next = 7'd0;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        select_next = MuxSelect + 3'd1;
                        strobe_next = 1'b1;
                    end
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed self-checking bench for mux_scan_sequencer
// with TICKS=4. Inputs change and outputs are sampled on the falling edge.
module tb_mux_scan_sequencer;

    localparam int TICKS = 4;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [6:0] DataIn;
    logic [2:0] Length;
    logic [6:0] MuxIn;
    logic [2:0] MuxSelect;
    logic       Busy;
    logic       BitStrobe;
    logic       Done;

    int checksTotal;
    int checksPassed;

    mux_scan_sequencer #(.TICKS(TICKS)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .DataIn    (DataIn),
        .Length    (Length),
        .MuxIn     (MuxIn),
        .MuxSelect (MuxSelect),
        .Busy      (Busy),
        .BitStrobe (BitStrobe),
        .Done      (Done)
    );

    // Free-running clock, 10 time units per period
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One comparison: counts it and reports a failure with both values
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Compare every DUT output against the expected values for this cycle
    task automatic checkAll(input string tag, input logic [6:0] expMuxIn,
                            input logic [2:0] expSel, input logic expBusy,
                            input logic expStrobe, input logic expDone);
        checkOutput({tag, " MuxIn"}, 32'(MuxIn), 32'(expMuxIn));
        checkOutput({tag, " MuxSelect"}, 32'(MuxSelect), 32'(expSel));
        checkOutput({tag, " Busy"}, 32'(Busy), 32'(expBusy));
        checkOutput({tag, " BitStrobe"}, 32'(BitStrobe), 32'(expStrobe));
        checkOutput({tag, " Done"}, 32'(Done), 32'(expDone));
    endtask

    // Present a one-cycle Start; returns in the first cycle of the scan
    task automatic applyStimulus(input logic [6:0] word, input logic [2:0] len);
        Start  = 1'b1;
        DataIn = word;
        Length = len;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Walk a whole scan cycle by cycle and finish checking in the Done cycle.
    // With disturb set, Start/DataIn/Length are poked at select 2, and Start
    // is raised with the next word during the final bit period.
    task automatic checkScan(input string tag, input logic [6:0] word,
                             input int effLen, input bit disturb,
                             input logic [6:0] nextWord, input logic [2:0] nextLen);
        logic [6:0] w;
        w = word;
        for (int b = 0; b < effLen; b++) begin
            for (int t = 0; t < TICKS; t++) begin
                string cyc;
                cyc = $sformatf("%s b%0d t%0d", tag, b, t);
                checkAll(cyc, word, 3'(b), 1'b1, (t == 0), 1'b0);
                checkOutput({cyc, " mux out"}, 32'(MuxIn[MuxSelect]), 32'(w[b]));
                if (disturb && b == 2 && t == 1) begin
                    Start  = 1'b1;
                    DataIn = ~word;
                    Length = 3'd1;
                end
                if (disturb && b == 2 && t == 2) begin
                    Start = 1'b0;
                end
                if (disturb && b == effLen - 1 && t == TICKS - 1) begin
                    Start  = 1'b1;
                    DataIn = nextWord;
                    Length = nextLen;
                end
                @(negedge Clock);
            end
        end
        checkAll({tag, " done"}, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        Reset  = 1'b1;
        Start  = 1'b1;
        DataIn = 7'h55;
        Length = 3'd7;

        // 1. Reset held two cycles with Start high
        repeat (2) @(negedge Clock);
        checkAll("reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checkAll($sformatf("post-reset idle %0d", i), 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // 2. Full 7-bit scan: mux output 1,0,0,1,1,0,1
        applyStimulus(7'b1011001, 3'd7);
        checkScan("scan7", 7'b1011001, 7, 1'b0, 7'd0, 3'd0);
        @(negedge Clock);
        checkAll("idle after scan7", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 3. Three-bit scan: mux output 0,1,1
        applyStimulus(7'b0000110, 3'd3);
        checkScan("scan3", 7'b0000110, 3, 1'b0, 7'd0, 3'd0);
        @(negedge Clock);
        checkAll("idle after scan3", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 4. Length 0 behaves as 7
        applyStimulus(7'h7F, 3'd0);
        checkScan("len0", 7'h7F, 7, 1'b0, 7'd0, 3'd0);
        @(negedge Clock);

        // 5. Mid-scan disturbance ignored, then back-to-back scan from Done cycle
        applyStimulus(7'b0110101, 3'd5);
        checkScan("disturb", 7'b0110101, 5, 1'b1, 7'b1010011, 3'd2);
        @(negedge Clock);
        Start = 1'b0;
        checkScan("back2back", 7'b1010011, 2, 1'b0, 7'd0, 3'd0);
        @(negedge Clock);
        checkAll("idle after back2back", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 6. Reset while the select sits at 3
        applyStimulus(7'b1100110, 3'd6);
        repeat (3 * TICKS) @(negedge Clock);
        checkAll("pre-abort", 7'b1100110, 3'd3, 1'b1, 1'b1, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkAll("abort", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * TICKS; i++) begin
            @(negedge Clock);
            checkAll($sformatf("after abort %0d", i), 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Recovery: a fresh scan runs normally after the abort
        applyStimulus(7'b0000010, 3'd2);
        checkScan("recover", 7'b0000010, 2, 1'b0, 7'd0, 3'd0);
        @(negedge Clock);
        checkAll("final idle", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
